top_scores_reader: RTL and testbench
====================================

// Module: top_scores_reader
// PURPOSE
//  Reader side of the TOP_SCORES leaderboard interface. On a refresh request it snapshots all places,
//  converts each 16-bit score to packed BCD using a sequential double-dabble, and streams one entry per
//  place (place 1 first) to the screen/text drawing logic over a valid/ready handshake.
//  Sits between the scores table and the leaderboard drawing/digit-ROM path.
// PARAMETERS
//  SCORE_WIDTH  16  score bit width; equals TOP_SCORES.placeScore width
//  BCD_DIGITS   5   BCD digits per score; 5 covers 0..65535
//  NUM_PLACES   3   places streamed per sweep; equals TOP_SCORES depth
// PORTS
//  clk          in   1                clock
//  resetN       in   1                asynchronous, active-low reset
//  topScores    in   TOP_SCORES       placeScore[0..2] (16b), placeIndex[0..2] (4b); place 1 = [0]
//  refresh      in   1                request a sweep; level sampled every cycle
//  entryReady   in   1                consumer accepts the current entry
//  entryValid   out  1                entry outputs valid
//  entryPlace   out  2                0-based place number (0..NUM_PLACES-1)
//  entryPlayer  out  4                placeIndex of the entry
//  entryDigits  out  4*BCD_DIGITS     packed BCD; [3:0] = units digit
//  entryEmpty   out  1                snapshot score == 0
//  busy         out  1                sweep in progress
//  done         out  1                one-cycle pulse after the final handshake
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; snapshot, pending and counters cleared. Reset mid-sweep aborts it
//   with no done pulse.
//  FSM states: IDLE, CONVERT, PRESENT, FINISH.
//  IDLE: refresh=1 at edge E0 -> copy all NUM_PLACES scores and indices into an internal snapshot,
//   place=0, load snapshot score 0 into the shift register, clear BCD, busy=1, go to CONVERT.
//  CONVERT: exactly SCORE_WIDTH edges. Each edge: add 3 to every BCD nibble >=5, then shift
//   {bcd,bin} left by 1. After the SCORE_WIDTH-th edge go to PRESENT.
//  PRESENT: entryValid=1. entryDigits, entryPlace, entryPlayer, and entryEmpty are registered and
//   held stable while entryValid && !entryReady.
//   Handshake edge = entryValid && entryReady:
//    place < NUM_PLACES-1: entryValid->0, place++, load the next snapshot score, go to CONVERT.
//    last place: entryValid->0, go to FINISH.
//  FINISH: lasts one cycle with done=1. Then busy->0 and go to IDLE. If pending=1, clear pending and go
//   directly to CONVERT with a fresh snapshot instead; busy stays 1 in that case.
//  Latency: entryValid rises SCORE_WIDTH edges after E0 or after a handshake edge (16 by default).
//  No combinational path from entryReady to entryValid.
//  refresh while busy, including the FINISH cycle: sets the pending flag. Multiple requests coalesce to
//   one extra sweep, never more. The current sweep is not restarted.
//  topScores changes after E0 do not affect the running sweep; output comes only from the snapshot.
//  Entries with score 0 are still streamed, with entryEmpty=1 and entryDigits=0.
//  Width rules: double-dabble is exact for any SCORE_WIDTH <= 3.33*BCD_DIGITS. Nibble adds wrap
//   within 4 bits and never overflow for valid parameters.
// TESTING
//  1 scores {12345/P3, 650/P1, 0/P0}, refresh pulse, ready=1 -> entries place0 digits 0x12345 player3,
//    place1 0x00650 player1, place2 0x00000 entryEmpty=1; entryValid rises 16 edges after E0; done
//    pulses once; busy falls the following cycle.
//  2 score 65535 -> entryDigits 0x65535. Score 9 -> 0x00009. Score 10000 -> 0x10000.
//  3 backpressure: ready low 5 cycles on place1 -> valid and all entry fields stable for all 5 cycles;
//    exactly one transfer when ready rises.
//  4 refresh held high for 3 cycles in mid-sweep -> exactly one further sweep after done. Refresh in
//    the FINISH cycle -> immediate second sweep with busy never dropping.
//  5 snapshot: change topScores 2 cycles after E0 -> all three entries show the old values.
//  6 resetN low during CONVERT of place1 -> all outputs 0 asynchronously; no done; after release, IDLE
//    until the next refresh.

Source files
------------

// File: rtl/top_scores_reader.sv
// TOP_SCORES leaderboard reader: snapshots all places on refresh, converts each score to BCD
// with a sequential double-dabble and streams one entry per place over valid/ready.
package top_scores_pkg;
    localparam int unsigned TS_SCORE_W = 16;
    localparam int unsigned TS_INDEX_W = 4;
    localparam int unsigned TS_PLACES  = 3;

    typedef struct packed {
        logic [TS_PLACES-1:0][TS_SCORE_W-1:0] placeScore;
        logic [TS_PLACES-1:0][TS_INDEX_W-1:0] placeIndex;
    } TOP_SCORES;
endpackage

module top_scores_reader
    import top_scores_pkg::*;
#(
    parameter int unsigned SCORE_WIDTH = TS_SCORE_W,
    parameter int unsigned BCD_DIGITS  = 5,
    parameter int unsigned NUM_PLACES  = TS_PLACES
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  TOP_SCORES                       topScores,
    input  logic                            refresh,
    input  logic                            entryReady,
    output logic                            entryValid,
    output logic [$clog2(NUM_PLACES)-1:0]   entryPlace,
    output logic [TS_INDEX_W-1:0]           entryPlayer,
    output logic [4*BCD_DIGITS-1:0]         entryDigits,
    output logic                            entryEmpty,
    output logic                            busy,
    output logic                            done
);

    localparam int unsigned PW = $clog2(NUM_PLACES);
    localparam int unsigned CW = $clog2(SCORE_WIDTH + 1);
    localparam int unsigned BW = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {IDLE, CONVERT, PRESENT, FINISH} state_t;

    state_t                  state_q, state_d;
    TOP_SCORES               snap_q, snap_d;
    logic [PW-1:0]           place_q, place_d, place_nxt;
    logic [SCORE_WIDTH-1:0]  bin_q, bin_d;
    logic [BW-1:0]           bcd_q, bcd_d, bcd_adj, bcd_shift;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    pending_q, pending_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    valid_q, valid_d;
    logic [PW-1:0]           oplace_q, oplace_d;
    logic [TS_INDEX_W-1:0]   player_q, player_d;
    logic [BW-1:0]           digits_q, digits_d;
    logic                    empty_q, empty_d;
    logic                    start;

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_shift = {bcd_adj[BW-2:0], bin_q[SCORE_WIDTH-1]};
    assign place_nxt = place_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        place_d   = place_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        oplace_d  = oplace_q;
        player_d  = player_q;
        digits_d  = digits_q;
        empty_d   = empty_q;
        start     = 1'b0;

        case (state_q)
            IDLE: start = refresh;
            CONVERT: begin
                pending_d = pending_q | refresh;
                bcd_d     = bcd_shift;
                bin_d     = bin_q << 1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CW'(SCORE_WIDTH - 1)) begin
                    state_d  = PRESENT;
                    valid_d  = 1'b1;
                    digits_d = bcd_shift;
                    oplace_d = place_q;
                    player_d = snap_q.placeIndex[place_q];
                    empty_d  = (snap_q.placeScore[place_q] == '0);
                end
            end
            PRESENT: begin
                pending_d = pending_q | refresh;
                if (valid_q && entryReady) begin
                    valid_d = 1'b0;
                    if (place_q == PW'(NUM_PLACES - 1)) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        place_d = place_nxt;
                        bin_d   = snap_q.placeScore[place_nxt];
                        bcd_d   = '0;
                        cnt_d   = '0;
                        state_d = CONVERT;
                    end
                end
            end
            FINISH: begin
                // A refresh arriving in this very cycle is folded into the pending request.
                if (pending_q || refresh) begin
                    pending_d = 1'b0;
                    start     = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            snap_d  = topScores;
            place_d = '0;
            bin_d   = topScores.placeScore[0];
            bcd_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = CONVERT;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            place_q   <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            oplace_q  <= '0;
            player_q  <= '0;
            digits_q  <= '0;
            empty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            place_q   <= place_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            oplace_q  <= oplace_d;
            player_q  <= player_d;
            digits_q  <= digits_d;
            empty_q   <= empty_d;
        end
    end

    assign entryValid  = valid_q;
    assign entryPlace  = oplace_q;
    assign entryPlayer = player_q;
    assign entryDigits = digits_q;
    assign entryEmpty  = empty_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_top_scores_reader.sv
// Directed bench for top_scores_reader: scoreboard of expected entries, checked on each handshake.
module tb_top_scores_reader;
    import top_scores_pkg::*;

    logic        clk = 1'b0;
    logic        resetN;
    TOP_SCORES   ts;
    logic        refresh;
    logic        entryReady;
    logic        entryValid;
    logic [1:0]  entryPlace;
    logic [3:0]  entryPlayer;
    logic [19:0] entryDigits;
    logic        entryEmpty;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [26:0] exp_q[$];

    top_scores_reader #(.SCORE_WIDTH(16), .BCD_DIGITS(5), .NUM_PLACES(3)) dut (
        .clk(clk), .resetN(resetN), .topScores(ts), .refresh(refresh),
        .entryReady(entryReady), .entryValid(entryValid), .entryPlace(entryPlace),
        .entryPlayer(entryPlayer), .entryDigits(entryDigits), .entryEmpty(entryEmpty),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        x = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [26:0] entry_of(input int unsigned place, input int unsigned score,
                                             input int unsigned idx);
        return {2'(place), 4'(idx), (score == 0), to_bcd(score)};
    endfunction

    function automatic logic [26:0] observed_entry();
        return {entryPlace, entryPlayer, entryEmpty, entryDigits};
    endfunction

    function automatic logic [29:0] all_outputs();
        return {entryValid, busy, done, entryEmpty, entryPlace, entryPlayer, entryDigits};
    endfunction

    task automatic set_scores(input int unsigned s0, input int unsigned i0, input int unsigned s1,
                              input int unsigned i1, input int unsigned s2, input int unsigned i2);
        ts.placeScore[0] = 16'(s0); ts.placeIndex[0] = 4'(i0);
        ts.placeScore[1] = 16'(s1); ts.placeIndex[1] = 4'(i1);
        ts.placeScore[2] = 16'(s2); ts.placeIndex[2] = 4'(i2);
    endtask

    task automatic push_sweep();
        for (int p = 0; p < 3; p++)
            exp_q.push_back(entry_of(p, ts.placeScore[p], ts.placeIndex[p]));
    endtask

    // Returns at the negedge following E0.
    task automatic pulse_refresh();
        @(negedge clk); refresh = 1'b1;
        @(negedge clk); refresh = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 200 && !entryValid; i++) @(negedge clk);
        check(tag, 32'(entryValid), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300 && !done; i++) @(negedge clk);
        check(tag, 32'(done), 32'd1);
    endtask

    // Handshake monitor: sampled just after the negedge, once stimulus for the next edge is set.
    always @(negedge clk) begin
        #1;
        if (resetN && entryValid && entryReady) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL entry_unexpected: observed %0h expected none", observed_entry());
            end else begin
                check("entry", 32'(observed_entry()), 32'(exp_q.pop_front()));
            end
        end
        if (resetN && done) done_cnt++;
    end

    initial begin
        int d0;
        int low_cnt;
        resetN = 1'b0; refresh = 1'b0; entryReady = 1'b0; ts = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(all_outputs()), 32'd0);
        resetN = 1'b1;
        @(negedge clk);

        // Basic sweep and latency
        set_scores(12345, 3, 650, 1, 0, 0);
        entryReady = 1'b1;
        d0 = done_cnt;
        push_sweep();
        pulse_refresh();
        check("busy_after_start", 32'(busy), 32'd1);
        repeat (15) @(negedge clk);
        check("latency_pre", 32'(entryValid), 32'd0);
        @(negedge clk);
        check("latency_valid", 32'(entryValid), 32'd1);
        check("latency_entry", 32'(observed_entry()), 32'(entry_of(0, 12345, 3)));
        wait_done("done_t1");
        check("busy_in_finish", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_fall", 32'(busy), 32'd0);
        check("done_fall", 32'(done), 32'd0);
        repeat (5) @(negedge clk);
        check("done_once", 32'(done_cnt - d0), 32'd1);

        // Conversion corner values
        set_scores(65535, 2, 9, 5, 10000, 7);
        push_sweep();
        pulse_refresh();
        wait_done("done_t2");
        @(negedge clk);

        // Backpressure on place1
        set_scores(111, 1, 2222, 2, 33333, 3);
        entryReady = 1'b0;
        push_sweep();
        pulse_refresh();
        wait_valid("bp_valid0");
        entryReady = 1'b1;
        @(negedge clk);
        entryReady = 1'b0;
        wait_valid("bp_valid1");
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(entryValid), 32'd1);
            check("bp_hold_fields", 32'(observed_entry()), 32'(entry_of(1, 2222, 2)));
            @(negedge clk);
        end
        entryReady = 1'b1;
        @(negedge clk);
        check("bp_one_transfer", 32'(entryValid), 32'd0);
        wait_done("done_t3");
        @(negedge clk);

        // Refresh held 3 cycles mid-sweep: exactly one extra sweep
        set_scores(500, 4, 77, 8, 1, 9);
        d0 = done_cnt;
        push_sweep();
        pulse_refresh();
        repeat (20) @(negedge clk);
        refresh = 1'b1;
        repeat (3) @(negedge clk);
        refresh = 1'b0;
        push_sweep();
        wait_done("done_t4a_first");
        @(negedge clk);
        check("pending_keeps_busy", 32'(busy), 32'd1);
        wait_done("done_t4a_second");
        @(negedge clk);
        check("pending_busy_fall", 32'(busy), 32'd0);
        repeat (60) @(negedge clk);
        check("pending_coalesced", 32'(done_cnt - d0), 32'd2);
        check("pending_idle", 32'(entryValid), 32'd0);

        // Refresh in the FINISH cycle
        push_sweep();
        pulse_refresh();
        wait_done("done_t4b_first");
        refresh = 1'b1;
        push_sweep();
        @(negedge clk);
        refresh = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (!busy) low_cnt++;
            @(negedge clk);
        end
        check("finish_busy_never_low", 32'(low_cnt), 32'd0);
        check("done_t4b_second", 32'(done), 32'd1);
        @(negedge clk);
        check("finish_busy_fall", 32'(busy), 32'd0);

        // Snapshot isolation
        set_scores(4321, 5, 808, 6, 0, 10);
        push_sweep();
        pulse_refresh();
        @(negedge clk);
        set_scores(1, 1, 2, 2, 3, 3);
        wait_done("done_t5");
        @(negedge clk);

        // Reset during CONVERT of place1
        set_scores(42, 1, 99, 2, 7, 3);
        d0 = done_cnt;
        exp_q.push_back(entry_of(0, 42, 1));
        pulse_refresh();
        repeat (22) @(negedge clk);
        resetN = 1'b0;
        #2;
        check("async_reset_outputs", 32'(all_outputs()), 32'd0);
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        repeat (40) @(negedge clk);
        check("post_reset_idle", 32'({entryValid, busy}), 32'd0);
        check("post_reset_no_done", 32'(done_cnt - d0), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
